// File: rtl/sram_rat_mp.sv
`default_nettype none
// ============================================================================
// Module   : sram_rat_mp
// Purpose  : Multi-port register-alias-table storage. It has NRD read ports and
//            NWR write ports, write-before-read bypass, and a post-reset init sweep.
// Revision : 1.0
// ============================================================================
module sram_rat_mp #(
  parameter int ADDRW     = 5,
  parameter int DATAW     = 6,
  parameter int NRD       = 2,
  parameter int NWR       = 2,
  parameter int INIT_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   ready,
  input  logic [NRD-1:0]         rd_en,
  input  logic [NRD*ADDRW-1:0]   rd_addr,
  output logic [NRD*DATAW-1:0]   rd_data,
  output logic [NRD-1:0]         rd_valid,
  input  logic [NWR-1:0]         wr_en,
  input  logic [NWR*ADDRW-1:0]   wr_addr,
  input  logic [NWR*DATAW-1:0]   wr_data
);

  localparam int DEPTH = 1 << ADDRW;

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                        state_q;
  logic [ADDRW-1:0]              cnt_q;
  logic                          ready_q;
  logic [NRD-1:0]                rd_valid_q;
  logic [NRD-1:0]                rd_valid_d;
  logic [NRD-1:0][DATAW-1:0]     rd_data_q;
  logic [NRD-1:0][DATAW-1:0]     rd_data_d;

  logic [DATAW-1:0]              mem_q [DEPTH];

  logic [NRD-1:0][ADDRW-1:0]     ra;
  logic [NWR-1:0][ADDRW-1:0]     wa;
  logic [NWR-1:0][DATAW-1:0]     wd;
  logic [NRD-1:0][DATAW-1:0]     byp;
  logic [DATAW-1:0]              init_data;
  logic                          run;

  assign ra  = rd_addr;
  assign wa  = wr_addr;
  assign wd  = wr_data;
  assign run = (state_q == S_RUN);

  assign ready    = ready_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

  // Identity init truncates or zero-extends the address to the entry width.
  generate
    if (INIT_MODE == 1) begin : g_init_ident
      if (DATAW <= ADDRW) begin : g_trunc
        assign init_data = cnt_q[DATAW-1:0];
      end else begin : g_ext
        assign init_data = {{(DATAW-ADDRW){1'b0}}, cnt_q};
      end
    end else begin : g_init_zero
      assign init_data = '0;
    end
  endgenerate

  // Later write ports override earlier ones, so the highest index wins.
  always_comb begin
    byp = '0;
    for (int i = 0; i < NRD; i++) begin
      byp[i] = mem_q[ra[i]];
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wa[j] == ra[i])) begin
          byp[i] = wd[j];
        end
      end
    end
  end

  always_comb begin
    rd_valid_d = rd_en & {NRD{run}};
    rd_data_d  = rd_data_q;
    for (int i = 0; i < NRD; i++) begin
      if (rd_valid_d[i]) begin
        rd_data_d[i] = byp[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_INIT;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == {ADDRW{1'b1}}) begin
            state_q <= S_RUN;
            ready_q <= 1'b1;
          end
        end
        S_RUN: begin
          state_q <= S_RUN;
        end
        default: begin
          state_q <= S_INIT;
        end
      endcase
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // The storage has no reset; the init sweep defines its contents.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      mem_q[cnt_q] <= init_data;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j]) begin
          mem_q[wa[j]] <= wd[j];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_rat_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_rat_mp
// Purpose  : Self-checking bench for sram_rat_mp. It uses a vector table, a read
//            scoreboard, and hand-written init and reset sequences.
// Revision : 1.0
// ============================================================================
module tb_sram_rat_mp;

  localparam int ADDRW = 5;
  localparam int DATAW = 6;
  localparam int NRD   = 4;
  localparam int NWR   = 2;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       ready;
  logic [NRD-1:0]             rd_en = '0;
  logic [NRD-1:0][ADDRW-1:0]  rd_addr = '0;
  logic [NRD-1:0][DATAW-1:0]  rd_data;
  logic [NRD-1:0]             rd_valid;
  logic [NWR-1:0]             wr_en = '0;
  logic [NWR-1:0][ADDRW-1:0]  wr_addr = '0;
  logic [NWR-1:0][DATAW-1:0]  wr_data = '0;

  sram_rat_mp #(
    .ADDRW(ADDRW), .DATAW(DATAW), .NRD(NRD), .NWR(NWR), .INIT_MODE(1)
  ) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NRD-1:0]            re;
    logic [NRD-1:0][ADDRW-1:0] ra;
    logic [NWR-1:0]            we;
    logic [NWR-1:0][ADDRW-1:0] wa;
    logic [NWR-1:0][DATAW-1:0] wd;
    logic [NRD-1:0][DATAW-1:0] ex;
  } vec_t;

  typedef struct {
    int               port;
    logic [DATAW-1:0] d;
  } exp_t;

  vec_t             tbl [11];
  exp_t             sbq [$];
  logic [DATAW-1:0] hold [NRD];
  int               n_cmp = 0;
  int               n_err = 0;

  function automatic vec_t mk(input logic [3:0] re, input int a0, a1, a2, a3,
                              input logic [1:0] we, input int wa0, wd0, wa1, wd1,
                              input int e0, e1, e2, e3);
    vec_t v;
    v.re = re;
    v.ra[0] = ADDRW'(a0); v.ra[1] = ADDRW'(a1); v.ra[2] = ADDRW'(a2); v.ra[3] = ADDRW'(a3);
    v.we = we;
    v.wa[0] = ADDRW'(wa0); v.wd[0] = DATAW'(wd0);
    v.wa[1] = ADDRW'(wa1); v.wd[1] = DATAW'(wd1);
    v.ex[0] = DATAW'(e0); v.ex[1] = DATAW'(e1); v.ex[2] = DATAW'(e2); v.ex[3] = DATAW'(e3);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    exp_t e;
    rd_en = v.re; rd_addr = v.ra;
    wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
    for (int i = 0; i < NRD; i++) begin
      if (v.re[i]) sbq.push_back('{i, v.ex[i]});
    end
    @(posedge clk); #1;
    rd_en = '0; wr_en = '0;
    chk({nm, " rd_valid"}, 32'(rd_valid), 32'(v.re));
    for (int i = 0; i < NRD; i++) begin
      if (v.re[i]) begin
        if (sbq.size() == 0) begin
          chk({nm, " scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("%s rd_data[%0d]", nm, e.port), 32'(rd_data[e.port]), 32'(e.d));
          hold[e.port] = e.d;
        end
      end else begin
        chk($sformatf("%s hold[%0d]", nm, i), 32'(rd_data[i]), 32'(hold[i]));
      end
    end
  endtask

  task automatic wait_ready(input string nm, input bit chk_valid);
    int n;
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (chk_valid) chk({nm, " init_rd_valid"}, 32'(rd_valid), 32'd0);
    end
    chk({nm, " init_cycles"}, 32'(n), 32'd32);
  endtask

  initial begin
    tbl[0]  = mk(4'b1111, 0, 7, 31, 3,  2'b00, 0, 0, 0, 0,         0, 7, 31, 3);
    tbl[1]  = mk(4'b0010, 0, 4, 0, 0,   2'b01, 4, 'h2A, 0, 0,      0, 'h2A, 0, 0);
    tbl[2]  = mk(4'b0000, 0, 0, 0, 0,   2'b00, 0, 0, 0, 0,         0, 0, 0, 0);
    tbl[3]  = mk(4'b0001, 9, 0, 0, 0,   2'b11, 9, 'h11, 9, 'h22,   'h22, 0, 0, 0);
    tbl[4]  = mk(4'b0100, 0, 0, 9, 0,   2'b00, 0, 0, 0, 0,         0, 0, 'h22, 0);
    tbl[5]  = mk(4'b0000, 0, 0, 0, 0,   2'b11, 1, 1, 2, 2,         0, 0, 0, 0);
    tbl[6]  = mk(4'b0001, 3, 0, 0, 0,   2'b01, 3, 3, 0, 0,         3, 0, 0, 0);
    tbl[7]  = mk(4'b1111, 1, 2, 3, 1,   2'b00, 0, 0, 0, 0,         1, 2, 3, 1);
    tbl[8]  = mk(4'b1011, 10, 4, 0, 11, 2'b11, 10, 5, 11, 6,       5, 'h2A, 0, 6);
    tbl[9]  = mk(4'b0100, 0, 0, 31, 0,  2'b01, 31, 'h3F, 31, 0,    0, 0, 'h3F, 0);
    tbl[10] = mk(4'b1001, 31, 0, 0, 2,  2'b00, 0, 0, 0, 0,         'h3F, 0, 0, 2);
    for (int i = 0; i < NRD; i++) hold[i] = '0;

    // Requests held during the whole init window must be ignored.
    rd_en = '1;
    for (int i = 0; i < NRD; i++) rd_addr[i] = 5'd3;
    wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 6'h3F;
    #22;
    chk("reset ready", 32'(ready), 32'd0);
    chk("reset rd_valid", 32'(rd_valid), 32'd0);
    chk("reset rd_data", 32'(rd_data), 32'd0);
    #1 rst = 1'b0;
    wait_ready("init1", 1'b1);
    rd_en = '0; wr_en = '0;

    for (int k = 0; k < 11; k++) apply(tbl[k], $sformatf("vec%0d", k));

    // Mid-operation asynchronous reset, applied between clock edges.
    apply(mk(4'b0000, 0, 0, 0, 0, 2'b01, 5, 'h15, 0, 0, 0, 0, 0, 0), "wr5");
    apply(mk(4'b0001, 5, 0, 0, 0, 2'b00, 0, 0, 0, 0, 'h15, 0, 0, 0), "rd5");
    #1 rst = 1'b1;
    #1;
    chk("async_rst ready", 32'(ready), 32'd0);
    chk("async_rst rd_valid", 32'(rd_valid), 32'd0);
    chk("async_rst rd_data", 32'(rd_data), 32'd0);
    #1 rst = 1'b0;
    sbq.delete();
    for (int i = 0; i < NRD; i++) hold[i] = '0;
    wait_ready("init2", 1'b0);
    apply(mk(4'b0011, 5, 4, 0, 0, 2'b00, 0, 0, 0, 0, 5, 4, 0, 0), "post_rst");

    chk("scoreboard drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
